// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control-unit bus between the sequencer (master) and memories/datapath (slave).
interface mips_multicycle_ctrl_if #(
    parameter int RETIRE_W = 32
);
    logic                run;
    logic [31:0]         imem_rdata;
    logic                imem_ack;
    logic                imem_req;
    logic                dmem_ack;
    logic                dmem_req;
    logic                dmem_we;
    logic [31:0]         ir_q;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                alu_src_imm;
    logic                rf_we;
    logic                rf_dst_rt;
    logic                link_we;
    logic                mem_to_reg;
    logic                fault;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  run, imem_rdata, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_q, ir_we, pc_we, pc_src, alu_src_imm,
               rf_we, rf_dst_rt, link_we, mem_to_reg, fault, retired
    );

    modport slave (
        output run, imem_rdata, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_q, ir_we, pc_we, pc_src, alu_src_imm,
               rf_we, rf_dst_rt, link_we, mem_to_reg, fault, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS sequencer with opcode classing, bounded memory waits and retire count.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT  = 15,
    parameter int RETIRE_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    state_e              state_q, state_d;
    logic [31:0]         ir_q;
    logic                fault_q, fault_d;
    logic [RETIRE_W-1:0] retired_q;
    logic [7:0]          cnt_q, cnt_d;
    logic [5:0]          op;
    logic                is_r, is_i, is_j, is_mem, is_ld, is_sw, legal;
    logic                imem_req, dmem_req, ir_we, req, ack, timeout, retire;

    assign op     = ir_q[31:26];
    assign is_r   = op == 6'b000000;
    assign is_j   = op inside {6'b000010, 6'b000011};
    assign is_ld  = op inside {6'b100000, 6'b100011};
    assign is_sw  = op == 6'b101011;
    assign is_mem = is_ld | is_sw;
    assign is_i   = is_mem | (op inside {6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b101010, 6'b001111});
    assign legal  = is_r | is_i | is_j;

    // A nonzero wait count keeps a fetch request alive even if run drops mid-wait.
    assign imem_req = state_q == FETCH && (bus.run || cnt_q != 8'd0);
    assign dmem_req = state_q == MEM;
    assign ir_we    = imem_req & bus.imem_ack;
    assign req      = imem_req | dmem_req;
    assign ack      = ir_we | (dmem_req & bus.dmem_ack);
    assign timeout  = req & ~ack & (cnt_q == 8'(TIMEOUT - 1));
    assign cnt_d    = (req & ~ack & ~timeout) ? cnt_q + 8'd1 : 8'd0;
    assign retire   = (state_q == EXEC && is_j) || (dmem_req && bus.dmem_ack && is_sw) || state_q == WB;
    assign fault_d  = fault_q | timeout | (state_q == DECODE && !legal);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= 32'd0;
            fault_q   <= 1'b0;
            retired_q <= '0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_we ? bus.imem_rdata : ir_q;
            fault_q   <= fault_d;
            retired_q <= retire ? retired_q + 1'b1 : retired_q;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = timeout ? HALT : ir_we ? DECODE : FETCH;
            DECODE:  state_d = legal ? EXEC : HALT;
            EXEC:    state_d = is_j ? FETCH : is_mem ? MEM : WB;
            MEM:     state_d = timeout ? HALT : !bus.dmem_ack ? MEM : is_sw ? FETCH : WB;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        bus.imem_req    = imem_req;
        bus.dmem_req    = dmem_req;
        bus.dmem_we     = dmem_req & is_sw;
        bus.ir_q        = ir_q;
        bus.ir_we       = ir_we;
        bus.pc_we       = ir_we | (state_q == EXEC && is_j);
        bus.pc_src      = ir_we ? 2'b00 : (state_q == EXEC && is_j) ? 2'b01 : 2'b10;
        bus.alu_src_imm = state_q == EXEC && is_i;
        bus.rf_we       = state_q == WB;
        bus.rf_dst_rt   = state_q == WB && is_i;
        bus.link_we     = state_q == EXEC && op == 6'b000011;
        bus.mem_to_reg  = state_q == WB && is_ld;
        bus.fault       = fault_q;
        bus.retired     = retired_q;
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of sequencing, memory handshakes, timeout, faults and retire wrap.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.RETIRE_W(4)) bus ();
    mips_multicycle_ctrl #(.TIMEOUT(15), .RETIRE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Zero-wait fetch from FETCH; returns during the DECODE cycle.
    task automatic fetch_instr(input logic [31:0] w);
        nxt();
        bus.run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = w;
        #1;
        check("fetch_imem_req", bus.imem_req, 1);
        check("fetch_ir_we", bus.ir_we, 1);
        check("fetch_pc_we", bus.pc_we, 1);
        check("fetch_pc_src", bus.pc_src, 0);
        nxt();
        bus.imem_ack = 1'b0;
        #1;
        check("dec_ir_q", bus.ir_q, w);
        check("dec_imem_req", bus.imem_req, 0);
        check("dec_ir_we", bus.ir_we, 0);
    endtask

    initial begin
        bus.run = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        nxt();
        #1;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_dmem_req", bus.dmem_req, 0);
        check("rst_pc_src", bus.pc_src, 2);
        check("rst_pc_we", bus.pc_we, 0);
        check("rst_ir_q", bus.ir_q, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_fault", bus.fault, 0);
        rst = 1'b0;
        // add: F,D,E,W
        fetch_instr(32'h0022_1820);
        nxt(); #1;
        check("add_exec_imm", bus.alu_src_imm, 0);
        check("add_exec_pc_we", bus.pc_we, 0);
        nxt(); #1;
        check("add_wb_rf_we", bus.rf_we, 1);
        check("add_wb_dst_rt", bus.rf_dst_rt, 0);
        check("add_wb_m2r", bus.mem_to_reg, 0);
        check("add_wb_retired", bus.retired, 0);
        nxt(); bus.run = 1'b0; #1;
        check("add_retired", bus.retired, 1);
        check("add_rf_we_off", bus.rf_we, 0);
        check("idle_imem_req", bus.imem_req, 0);
        // lw with three wait cycles
        fetch_instr(32'h8C22_0004);
        nxt(); #1;
        check("lw_exec_imm", bus.alu_src_imm, 1);
        check("lw_exec_dmem_req", bus.dmem_req, 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            check("lw_wait_dmem_req", bus.dmem_req, 1);
            check("lw_wait_dmem_we", bus.dmem_we, 0);
        end
        nxt(); bus.dmem_ack = 1'b1; #1;
        check("lw_ack_dmem_req", bus.dmem_req, 1);
        nxt(); bus.dmem_ack = 1'b0; #1;
        check("lw_wb_rf_we", bus.rf_we, 1);
        check("lw_wb_m2r", bus.mem_to_reg, 1);
        check("lw_wb_dst_rt", bus.rf_dst_rt, 1);
        check("lw_wb_dmem_req", bus.dmem_req, 0);
        nxt(); bus.run = 1'b0; #1;
        check("lw_retired", bus.retired, 2);
        // jal
        fetch_instr(32'h0C00_0010);
        nxt(); #1;
        check("jal_pc_src", bus.pc_src, 1);
        check("jal_pc_we", bus.pc_we, 1);
        check("jal_link_we", bus.link_we, 1);
        check("jal_rf_we", bus.rf_we, 0);
        check("jal_retired_pre", bus.retired, 2);
        nxt(); bus.run = 1'b0; #1;
        check("jal_retired", bus.retired, 3);
        check("jal_link_off", bus.link_we, 0);
        check("jal_pc_src_hold", bus.pc_src, 2);
        // illegal opcode
        fetch_instr(32'hFC00_0000);
        check("ill_dec_fault", bus.fault, 0);
        nxt(); #1;
        check("ill_fault", bus.fault, 1);
        check("ill_imem_req", bus.imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); bus.imem_ack = 1'b1; #1;
            check("halt_imem_req", bus.imem_req, 0);
            check("halt_ir_we", bus.ir_we, 0);
        end
        nxt(); bus.imem_ack = 1'b0; rst = 1'b1;
        nxt(); rst = 1'b0; bus.run = 1'b0; #1;
        check("ill_rst_fault", bus.fault, 0);
        check("ill_rst_retired", bus.retired, 0);
        // sw timeout
        fetch_instr(32'hAC22_0004);
        nxt(); #1;
        check("sw_exec_imm", bus.alu_src_imm, 1);
        for (int i = 0; i < 15; i++) begin
            nxt(); #1;
            check("sw_wait_dmem_req", bus.dmem_req, 1);
            check("sw_wait_dmem_we", bus.dmem_we, 1);
        end
        nxt(); #1;
        check("sw_to_dmem_req", bus.dmem_req, 0);
        check("sw_to_fault", bus.fault, 1);
        nxt(); bus.dmem_ack = 1'b1; #1;
        check("sw_late_retired", bus.retired, 0);
        nxt(); bus.dmem_ack = 1'b0; #1;
        check("sw_late_retired2", bus.retired, 0);
        check("sw_late_fault", bus.fault, 1);
        check("sw_late_rf_we", bus.rf_we, 0);
        check("sw_late_imem_req", bus.imem_req, 0);
        // reset mid-MEM
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0; bus.run = 1'b0;
        fetch_instr(32'h8C22_0004);
        nxt();
        nxt(); #1;
        check("mid_mem_dmem_req", bus.dmem_req, 1);
        rst = 1'b1;
        nxt(); rst = 1'b0; bus.run = 1'b0; bus.dmem_ack = 1'b1; #1;
        check("mid_rst_dmem_req", bus.dmem_req, 0);
        check("mid_rst_retired", bus.retired, 0);
        check("mid_rst_imem_req", bus.imem_req, 0);
        nxt(); bus.dmem_ack = 1'b0; #1;
        check("mid_rst_late_ack", bus.retired, 0);
        check("mid_rst_rf_we", bus.rf_we, 0);
        // retire counter wrap with 4-bit width
        for (int i = 1; i <= 16; i++) begin
            fetch_instr(32'h0800_0000);
            nxt(); #1;
            check("j_pc_src", bus.pc_src, 1);
            check("j_link_we", bus.link_we, 0);
            nxt(); bus.run = 1'b0; #1;
            check("j_retired", bus.retired, 32'(i % 16));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
